serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  minuend; captured on accepted start.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 SHALL have port: busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-008 SHALL have port: done  output  1  one-cycle pulse when the result is valid.
REQ-009 SHALL have port: diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-010 SHALL have port: borrow_out  output  1  high when a < b (unsigned).

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
- IDLE->RUN on start=1.
- RUN->DONE after exactly WIDTH bit steps.
- DONE->IDLE unconditionally after one cycle.
REQ-012 SHALL, on accepted start, latch a and b into internal shift registers, clear the bit counter, and clear the borrow flop to 0.
REQ-013 SHALL, in each RUN cycle, process one bit, LSB first:
- d = x XOR y XOR bin
- bout = (NOT x AND y) OR (NOT (x XOR y) AND bin)
- shift d into the result register from the MSB side.
- store bout in the borrow flop.
REQ-014 SHALL use a bit counter of ceil(log2(WIDTH+1)) bits; it SHALL leave RUN when the counter reaches WIDTH-1 on the step being processed.
REQ-015 SHALL meet this latency:
- start sampled high at edge N.
- done=1 for exactly the cycle following edge N+WIDTH+1.
- diff/borrow_out valid from that cycle onward.
REQ-016 SHALL hold diff and borrow_out stable after done until the next accepted start; they SHALL not change during a subsequent RUN until that operation's final bit is shifted in (result register separate from output register, loaded on RUN->DONE).
REQ-017 SHALL ignore start while busy=1; operands presented then have no effect.
REQ-018 SHALL accept a start asserted in the same cycle done is high only after returning to IDLE, i.e. the earliest accepted restart is the cycle after done.
REQ-019 SHALL drive busy=1 in RUN and DONE and busy=0 in IDLE.
REQ-020 SHALL produce correct results for all boundary operands: a=b, a=0, b=0, all-ones.

Reset
REQ-021 SHALL, while rst=1 and regardless of clk, force: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, borrow flop=0.
REQ-022 SHALL abort an in-flight operation on reset mid-RUN; no done pulse SHALL follow, and the aborted result SHALL be discarded.
REQ-023 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-024 SHALL place the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) as localparams in a shared package/include serial_sub_pkg.
REQ-025 SHALL instantiate one sub-module full_subtractor (inputs x, y, bin; outputs d, bout), gate-level, for the per-bit cell of REQ-013.
REQ-026 SHALL contain no combinational path from start, a or b to any output.

Verification (WIDTH=8)
REQ-027 SHALL verify: a=200, b=75, start pulse -> done 9 cycles after start edge; diff=125, borrow_out=0.
REQ-028 SHALL verify: a=5, b=9 -> diff=252, borrow_out=1; a=0, b=255 -> diff=1, borrow_out=1; a=0, b=0 -> diff=0, borrow_out=0.
REQ-029 SHALL verify: start held high with new operands (a=1, b=1) during RUN of 200-75 -> single done; result 125/0; a second done (diff=0) only after a restart in IDLE.
REQ-030 SHALL verify: rst pulsed on the 4th RUN cycle -> outputs immediately 0, no done; next start with a=10, b=3 -> diff=7, borrow_out=0.
REQ-031 SHALL verify: a bench scoreboard compares 1000 random operand pairs against (a-b) mod 256 and (a<b), with back-to-back starts issued the cycle after each done.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and state type.
package serial_sub_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  // Width of a counter able to hold the values 0..width
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from gate primitives: d = x - y - bin, bout = borrow.
module full_subtractor (
  input  wire x,
  input  wire y,
  input  wire bin,
  output wire d,
  output wire bout
);

  wire w_xy;
  wire w_nx;
  wire w_nxy;
  wire w_t0;
  wire w_t1;

  xor g_xor0 (w_xy, x, y);
  xor g_xor1 (d, w_xy, bin);
  not g_not0 (w_nx, x);
  and g_and0 (w_t0, w_nx, y);
  not g_not1 (w_nxy, w_xy);
  and g_and1 (w_t1, w_nxy, bin);
  or  g_or0  (bout, w_t0, w_t1);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per cycle, LSB first.
// The result is shifted into a working register and copied to a separate output
// register only when the last bit is produced, so diff/borrow_out stay stable
// across a following operation until its result is complete.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           r_state_q;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_a_q;
  logic [WIDTH-1:0] r_b_q;
  logic [WIDTH-1:0] r_res_q;
  logic [WIDTH-1:0] r_diff_q;
  logic [CntW-1:0]  r_cnt_q;
  logic             r_bor_q;
  logic             r_borrow_out_q;
  // First RUN cycle is an alignment cycle with no bit step; it places done on
  // the cycle after edge N+WIDTH+1 for a start accepted at edge N.
  logic             r_align_q;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_d;
  logic             w_bout;

  full_subtractor u_full_subtractor (
    .x    (r_a_q[0]),
    .y    (r_b_q[0]),
    .bin  (r_bor_q),
    .d    (w_d),
    .bout (w_bout)
  );

  // Decode handshake/step qualifiers from current state only
  always_comb begin
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_last   = 1'b0;
    w_accept = (r_state_q == StIdle) && start;
    w_step   = (r_state_q == StRun) && !r_align_q;
    w_last   = w_step && (r_cnt_q == CntLast);
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state_q;
    unique case (r_state_q)
      StIdle:  if (start) w_state_d = StRun;
      StRun:   if (w_last) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= StIdle;
    end else begin
      r_state_q <= w_state_d;
    end
  end

  // Operand shift registers, working result, bit counter and borrow flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_q     <= '0;
      r_b_q     <= '0;
      r_res_q   <= '0;
      r_cnt_q   <= '0;
      r_bor_q   <= 1'b0;
      r_align_q <= 1'b0;
    end else if (w_accept) begin
      r_a_q     <= a;
      r_b_q     <= b;
      r_res_q   <= '0;
      r_cnt_q   <= '0;
      r_bor_q   <= 1'b0;
      r_align_q <= 1'b1;
    end else if (r_state_q == StRun) begin
      if (r_align_q) begin
        r_align_q <= 1'b0;
      end else begin
        r_a_q   <= r_a_q >> 1;
        r_b_q   <= r_b_q >> 1;
        r_res_q <= {w_d, r_res_q[WIDTH-1:1]};
        r_bor_q <= w_bout;
        r_cnt_q <= r_cnt_q + CntW'(1);
      end
    end
  end

  // Output register: loaded with the finished result on the final bit step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff_q       <= '0;
      r_borrow_out_q <= 1'b0;
    end else if (w_last) begin
      r_diff_q       <= {w_d, r_res_q[WIDTH-1:1]};
      r_borrow_out_q <= w_bout;
    end
  end

  // Outputs depend on registered state only
  always_comb begin
    busy       = (r_state_q != StIdle);
    done       = (r_state_q == StDone);
    diff       = r_diff_q;
    borrow_out = r_borrow_out_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed boundary cases,
// reset abort, start-while-busy, and 1000 random back-to-back operations.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;
  localparam int          Lat   = WIDTH + 2; // negedges from accept edge to done

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bor;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_done   = 0;
  int   n_issued = 0;
  exp_t last_res;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic modulo 2^WIDTH
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    int   d;
    d      = int'(x) - int'(y);
    e.diff = WIDTH'((d + (1 << WIDTH)) % (1 << WIDTH));
    e.bor  = (x < y);
    return e;
  endfunction

  task automatic push(input exp_t e);
    exp_q.push_back(e);
    n_issued++;
  endtask

  // Monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("diff", 32'(diff), 32'(e.diff));
        check("borrow_out", 32'(borrow_out), 32'(e.bor));
      end
    end
  end

  // Issue a start in the next cycle; returns just after the accepting edge
  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input bit do_push, output exp_t e);
    e = model(x, y);
    @(posedge clk);
    #1;
    a     = x;
    b     = y;
    start = 1'b1;
    if (do_push) push(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
  endtask

  // Wait for done; checks latency and that outputs held the previous result
  task automatic wait_done(input exp_t e, input bit chk_lat);
    int k;
    bit seen;
    bit stable;
    k      = 0;
    seen   = 1'b0;
    stable = 1'b1;
    while (!seen && k < Lat + 4) begin
      k++;
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (diff !== last_res.diff || borrow_out !== last_res.bor) stable = 1'b0;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done at %0d", k, Lat);
    end else begin
      if (chk_lat) check("latency", 32'(k), 32'(Lat));
      check("hold_prev_result", 32'(stable), 32'd1);
    end
    last_res = e;
  endtask

  initial begin
    exp_t e;
    logic [WIDTH-1:0] ta [7];
    logic [WIDTH-1:0] tb [7];
    ta = '{8'd200, 8'd5, 8'd0,   8'd0, 8'd255, 8'd255, 8'd128};
    tb = '{8'd75,  8'd9, 8'd255, 8'd0, 8'd255, 8'd0,   8'd128};

    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    last_res = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0;

    // 200-75, 5-9, 0-255
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i], 1'b1, e);
      wait_done(e, 1'b1);
    end

    // Reset in the 4th RUN cycle of 200-75: outputs clear at once, no done follows
    start_op(8'd200, 8'd75, 1'b0, e);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    last_res = '0;
    @(posedge clk);
    @(negedge clk);
    // Start presented together with reset release: accepted on the next edge
    rst   = 1'b0;
    a     = 8'd10;
    b     = 8'd3;
    start = 1'b1;
    e     = model(8'd10, 8'd3);
    push(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(e, 1'b1);

    // Boundary operands: 0-0, all-ones equal, all-ones minus zero, a=b
    for (int i = 3; i < 7; i++) begin
      start_op(ta[i], tb[i], 1'b1, e);
      wait_done(e, 1'b1);
    end

    // Start held high with new operands during RUN and through the done cycle
    e = model(8'd200, 8'd75);
    @(posedge clk);
    #1;
    a     = 8'd200;
    b     = 8'd75;
    start = 1'b1;
    push(e);
    @(posedge clk);
    #1;
    a = 8'd1;
    b = 8'd1;
    wait_done(e, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("start_in_done_ignored", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    check("idle_after_hold", 32'(busy), 32'd0);
    start_op(8'd1, 8'd1, 1'b1, e);
    wait_done(e, 1'b1);

    // Random back-to-back operations
    for (int i = 0; i < 1000; i++) begin
      start_op(WIDTH'($urandom), WIDTH'($urandom), 1'b1, e);
      wait_done(e, 1'b1);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_issued));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by t=%0t, expected bench to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
